// File: rtl/adc0809_ctrl.sv
// ADC0809 conversion controller: free-running adc_clk divider, ALE/START pulse, EOC handshake, OE read.
// Latency: busy -> adc_start +1 cycle, EOC pin -> dout_valid 3+OE_CYC cycles; start ignored while busy (no queue).
module adc0809_ctrl #(
    parameter int unsigned ADC_HALF  = 28,
    parameter int unsigned START_CYC = 10,
    parameter int unsigned OE_CYC    = 8,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] ch,
    output logic       busy,
    output logic [7:0] dout,
    output logic [2:0] dout_ch,
    output logic       dout_valid,
    output logic       timeout_err,
    output logic       adc_clk,
    output logic [2:0] adc_addr,
    output logic       adc_ale,
    output logic       adc_start,
    output logic       adc_oe,
    input  logic       adc_eoc,
    input  logic [7:0] adc_data
);
    localparam int unsigned DIV_W  = (ADC_HALF > 1) ? $clog2(ADC_HALF) : 1;
    localparam int unsigned PH_MAX = (START_CYC > OE_CYC) ? START_CYC : OE_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ADC_HALF - 1);
    localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYC - 1);
    localparam logic [PH_W-1:0]  OE_LAST    = PH_W'(OE_CYC - 1);
    localparam logic [15:0]      TMO_MAX    = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_READ
    } state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             adc_clk_q, adc_clk_d;

    always_comb begin
        div_d     = div_q + 1'b1;
        adc_clk_d = adc_clk_q;
        if (div_q == DIV_LAST) begin
            div_d     = '0;
            adc_clk_d = ~adc_clk_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            adc_clk_q <= adc_clk_d;
        end
    end

    // EOC idles high on the chip, so the synchroniser resets to 1 to avoid a false falling edge.
    logic eoc_m_q, eoc_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eoc_m_q <= 1'b1;
            eoc_s_q <= 1'b1;
        end else begin
            eoc_m_q <= adc_eoc;
            eoc_s_q <= eoc_m_q;
        end
    end

    state_t          state_q;
    logic [PH_W-1:0] ph_q;
    logic [15:0]     tmo_q;
    logic            busy_q;
    logic            pulse_q;
    logic            oe_q;
    logic            vld_q;
    logic            tmo_err_q;
    logic [2:0]      addr_q;
    logic [2:0]      dout_ch_q;
    logic [7:0]      dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
            oe_q      <= 1'b0;
            vld_q     <= 1'b0;
            tmo_err_q <= 1'b0;
            addr_q    <= '0;
            dout_ch_q <= '0;
            dout_q    <= '0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= ch;
                        busy_q    <= 1'b1;
                        tmo_err_q <= 1'b0;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    pulse_q <= 1'b1;
                    ph_q    <= '0;
                    state_q <= S_PULSE;
                end
                S_PULSE: begin
                    if (ph_q == START_LAST) begin
                        pulse_q <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_WAIT_LO;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                S_WAIT_LO, S_WAIT_HI: begin
                    // One timeout budget spans both EOC phases, measured from the START fall.
                    if (tmo_q == TMO_MAX) begin
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (state_q == S_WAIT_LO && !eoc_s_q) begin
                            state_q <= S_WAIT_HI;
                        end else if (state_q == S_WAIT_HI && eoc_s_q) begin
                            oe_q    <= 1'b1;
                            ph_q    <= '0;
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (ph_q == OE_LAST) begin
                        oe_q      <= 1'b0;
                        dout_q    <= adc_data;
                        dout_ch_q <= addr_q;
                        vld_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign dout        = dout_q;
    assign dout_ch     = dout_ch_q;
    assign dout_valid  = vld_q;
    assign timeout_err = tmo_err_q;
    assign adc_clk     = adc_clk_q;
    assign adc_addr    = addr_q;
    assign adc_ale     = pulse_q;
    assign adc_start   = pulse_q;
    assign adc_oe      = oe_q;

endmodule

// File: tb/tb_adc0809_ctrl.sv
// Directed bench for adc0809_ctrl: a behavioural ADC0809 drives EOC/data, expectations are hand-derived.
module tb_adc0809_ctrl;
    localparam int START_CYC = 10;
    localparam int OE_CYC    = 8;
    localparam int ADC_HALF  = 28;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] ch;
    logic       busy;
    logic [7:0] dout;
    logic [2:0] dout_ch;
    logic       dout_valid;
    logic       timeout_err;
    logic       adc_clk;
    logic [2:0] adc_addr;
    logic       adc_ale;
    logic       adc_start;
    logic       adc_oe;
    logic       adc_eoc;
    logic [7:0] adc_data;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    int clk_bad = 0;
    int clk_runs = 0;
    logic [7:0] last_dout = 8'h00;

    adc0809_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch         (ch),
        .busy       (busy),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .timeout_err(timeout_err),
        .adc_clk    (adc_clk),
        .adc_addr   (adc_addr),
        .adc_ale    (adc_ale),
        .adc_start  (adc_start),
        .adc_oe     (adc_oe),
        .adc_eoc    (adc_eoc),
        .adc_data   (adc_data)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (dout_valid === 1'b1) n_valid++;

    // Every adc_clk high/low run must be exactly ADC_HALF system clocks while out of reset.
    logic clk_prev = 1'b0;
    int   run_len = 0;
    bit   run_armed = 1'b0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            run_len   = 0;
            run_armed = 1'b0;
            clk_prev  = 1'b0;
        end else if (adc_clk !== clk_prev) begin
            if (run_armed) begin
                clk_runs++;
                if (run_len != ADC_HALF) clk_bad++;
            end
            run_armed = 1'b1;
            run_len   = 1;
            clk_prev  = adc_clk;
        end else begin
            run_len++;
        end
    end

    task automatic do_conv(input logic [2:0] c, input logic [7:0] d, input logic [2:0] c_after,
                           input bit hold, input bit glitch, input int lo_dly, input int hi_dly);
        int n;
        int ns;
        int vbase;
        bit oe_seen;
        vbase    = n_valid;
        ch       = c;
        start    = 1'b1;
        adc_data = ~d;
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        chk("accept", 32'(busy), 1);
        chk("setup_addr", 32'(adc_addr), 32'(c));
        chk("setup_ale_low", 32'(adc_ale), 0);
        chk("err_cleared", 32'(timeout_err), 0);
        ch = c_after;
        if (!hold) start = 1'b0;
        n = 0;
        while (!adc_ale && n < 20) begin @(negedge clk); n++; end
        chk("ale_delay", n, 1);
        n  = 0;
        ns = 0;
        while (adc_ale && n < 50) begin
            if (adc_start) ns++;
            n++;
            @(negedge clk);
        end
        chk("ale_width", n, START_CYC);
        chk("start_width", ns, START_CYC);
        chk("addr_held", 32'(adc_addr), 32'(c));
        repeat (lo_dly) @(negedge clk);
        #3 adc_eoc = 1'b0;
        if (glitch) begin
            repeat (10) @(negedge clk);
            #5 adc_eoc = 1'b1;
            #6 adc_eoc = 1'b0;
            oe_seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (adc_oe) oe_seen = 1'b1;
            end
            chk("glitch_no_read", 32'(oe_seen), 0);
        end
        repeat (hi_dly) @(negedge clk);
        #7 adc_eoc = 1'b1;
        n = 0;
        while (!adc_oe && n < 20) begin @(negedge clk); n++; end
        chk("eoc_to_oe", n, 3);
        adc_data = d;
        n = 0;
        while (adc_oe && n < 50) begin n++; @(negedge clk); end
        chk("oe_width", n, OE_CYC);
        chk("valid_pulse", 32'(dout_valid), 1);
        chk("dout", 32'(dout), 32'(d));
        chk("dout_ch", 32'(dout_ch), 32'(c));
        chk("busy_done", 32'(busy), 0);
        adc_data = ~d;
        @(negedge clk);
        chk("valid_width", 32'(dout_valid), 0);
        chk("valid_count", n_valid - vbase, 1);
        if (hold) chk("b2b_accept", 32'(busy), 1);
        last_dout = d;
    endtask

    initial begin
        int n;
        int vbase;
        rst      = 1'b0;
        start    = 1'b0;
        ch       = 3'd0;
        adc_eoc  = 1'b1;
        adc_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_pins", 32'({adc_clk, adc_addr, adc_ale, adc_start, adc_oe}), 0);
        chk("rst_tmo_err", 32'(timeout_err), 0);

        rst = 1'b1;
        n = 0;
        while (!adc_clk && n < 100) begin @(negedge clk); n++; end
        chk("adc_clk_first_rise", n, ADC_HALF);

        // Basic conversion: EOC low 2 us after START falls, high 100 us later.
        do_conv(3'd5, 8'hA7, 3'd2, 1'b0, 1'b0, 50, 2500);
        repeat (4) @(negedge clk);

        // start held high: back-to-back ch0/ch7, ch changes while busy must not leak in.
        do_conv(3'd0, 8'h00, 3'd7, 1'b1, 1'b0, 5, 60);
        do_conv(3'd7, 8'hFF, 3'd0, 1'b0, 1'b0, 5, 60);
        repeat (4) @(negedge clk);

        // Sub-cycle EOC glitch in WAIT_HI must not start the read.
        do_conv(3'd2, 8'h3C, 3'd4, 1'b0, 1'b1, 7, 30);
        repeat (4) @(negedge clk);

        // EOC stuck high: timeout.
        vbase   = n_valid;
        adc_eoc = 1'b1;
        ch      = 3'd3;
        start   = 1'b1;
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        start = 1'b0;
        n = 0;
        while (!adc_ale && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (adc_ale && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (busy && n < 70000) begin n++; @(negedge clk); end
        chk("tmo_len", 32'(n >= 65535 && n <= 65536), 1);
        chk("tmo_err_set", 32'(timeout_err), 1);
        chk("tmo_no_valid", n_valid - vbase, 0);
        chk("tmo_dout_kept", 32'(dout), 32'(last_dout));
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", 32'(timeout_err), 1);
        do_conv(3'd1, 8'h5A, 3'd6, 1'b0, 1'b0, 10, 40);
        repeat (4) @(negedge clk);

        // Asynchronous reset while waiting for EOC high.
        vbase    = n_valid;
        ch       = 3'd4;
        start    = 1'b1;
        adc_data = 8'hC3;
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        start = 1'b0;
        n = 0;
        while (!adc_ale && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (adc_ale && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        #3 adc_eoc = 1'b0;
        repeat (20) @(negedge clk);
        #7 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_dout", 32'({dout, dout_ch}), 0);
        chk("arst_pins", 32'({adc_clk, adc_addr, adc_ale, adc_start, adc_oe, dout_valid, timeout_err}), 0);
        adc_eoc = 1'b1;
        repeat (3) @(negedge clk);
        #5 rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_valid", n_valid - vbase, 0);
        chk("arst_idle", 32'(busy), 0);
        do_conv(3'd6, 8'h81, 3'd3, 1'b0, 1'b0, 8, 50);
        repeat (4) @(negedge clk);

        chk("adc_clk_bad_runs", clk_bad, 0);
        chk("adc_clk_runs_seen", 32'(clk_runs > 100), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
